xor_stream_unit: RTL and testbench
==================================

# xor_stream_unit

Parametrised, handshaked successor to the plain two-operand XOR datapath. Combines two DATA_WIDTH operands per accepted beat in one of four modes: pairwise XOR, pairwise XNOR, burst-accumulating XOR, and compare. Results leave through a registered valid/ready output stage with a 2-entry skid buffer. Sits between an operand producer and a result consumer in the streaming datapath.

## Interface
- DATA_WIDTH, 10, operand/result width (≥1)
- MAX_BURST, 16, max beats folded in ACCUM mode before forced emission (≥2)
- CNT_W, $clog2(MAX_BURST+1), derived width of o__count
- i__clk  in  1  clock, all logic rising-edge
- i__areset_n  in  1  asynchronous active-low reset
- i__sreset_n  in  1  synchronous active-low clear, same effect as i__areset_n at next edge
- i__valid  in  1  operand beat valid
- o__ready  out  1  unit can accept a beat
- i__mode  in  2  0 XOR, 1 XNOR, 2 ACCUM, 3 CMP
- i__last  in  1  last beat of ACCUM burst (ignored in other modes)
- i__inA  in  DATA_WIDTH  operand A
- i__inB  in  DATA_WIDTH  operand B
- o__valid  out  1  result valid
- i__ready  in  1  consumer accepts result
- o__dout  out  DATA_WIDTH  result
- o__parity  out  1  XOR-reduction of o__dout
- o__neq  out  1  CMP: |(A^B); 0 in other modes
- o__count  out  CNT_W  beats folded into this result (1 for non-ACCUM)
- o__ovf  out  1  ACCUM result emitted due to MAX_BURST, not i__last

## Operation
- Beat accepted when i__valid && o__ready.
- XOR: result A^B. XNOR: ~(A^B). CMP: result A^B, o__neq = |(A^B). One result per beat, count=1, ovf=0.
- ACCUM: accumulator acc (DATA_WIDTH) and beat counter. Each accepted beat: acc ^= A^B, cnt++. Emit acc^A^B with count=cnt+1 when i__last=1 or cnt+1==MAX_BURST (the latter sets ovf=1 unless i__last also 1). acc, cnt clear on emit.
- Burst FSM: IDLE → BURST on first ACCUM beat without emission; BURST → IDLE on emitting beat. In BURST, i__mode is ignored; every beat is treated as ACCUM until emission.
- A single-beat ACCUM with i__last=1 emits A^B, count=1.
- Results enter the skid buffer in acceptance order; no reordering, no drop.
- o__parity computed from the stored result, valid with o__dout.

## Timing
- Reset (either): o__valid=0, o__dout=0, o__parity=0, o__neq=0, o__count=0, o__ovf=0, o__ready=0, acc=0, cnt=0, FSM=IDLE, skid empty.
- o__ready is registered: rises on the first edge after reset release; thereafter o__ready = skid buffer not full (at most 1 occupied entry at edge).
- Latency: emitting beat accepted at edge N → o__valid=1 with result after edge N (visible cycle N+1).
- Throughput: 1 beat/cycle while i__ready=1. Under i__ready=0, at most 2 results buffered, then o__ready=0.
- o__valid/o__dout etc. held stable while o__valid && !i__ready.
- Simultaneous accept and pop on a full-by-one buffer: both occur; o__ready stays 1.
- i__areset_n assertion mid-burst: outputs clear immediately (asynchronously); partial burst discarded.
- i__sreset_n low: same clear at next edge; beat presented that cycle is not accepted.

## Structure
- Package xor_stream_pkg: typedef enum logic [1:0] xor_mode_e {XOR_M, XNOR_M, ACCUM_M, CMP_M}; typedef enum logic burst_state_e {IDLE, BURST}; result struct type parameterised via DATA_WIDTH at point of use.
- Sub-module xor_skid_buf: 2-entry valid/ready skid buffer, parameterised payload width (DATA_WIDTH+CNT_W+3); top holds mode decode, accumulator, counter, FSM.

## Test plan
- XOR: A=0x3FF, B=0x155 → next cycle o__dout=0x2AA, o__parity=1, o__count=1, o__neq=0.
- XNOR then CMP: A=B=0x0F0 → XNOR o__dout=0x3FF, parity=0; CMP o__dout=0x000, o__neq=0.
- ACCUM: (0x001,0x000),(0x002,0x000),(0x004,0x000,last) → exactly one result 0x007, count=3, ovf=0; mode toggled to XOR on beat 2 has no effect.
- Overflow, MAX_BURST=4: 5 ACCUM beats A=0x001..0x005, B=0, no last → result 0x004 (1^2^3^4), count=4, ovf=1; beat 5 opens a new burst.
- Backpressure: continuous XOR beats, i__ready=0 for 5 cycles → o__ready drops after 2 buffered results, all results delivered in order after release, none lost or duplicated.
- Reset mid-burst: 2 ACCUM beats (0x0AA,0), then i__areset_n low one cycle → outputs 0 immediately; new burst (0x003,0,last) yields 0x003, count=1.

Source files
------------

// File: rtl/xor_stream_pkg.sv
// Shared types for the XOR stream unit: operand-combine modes and the
// accumulate-burst FSM state.
package xor_stream_pkg;

  typedef enum logic [1:0] {
    XOR_M   = 2'd0,
    XNOR_M  = 2'd1,
    ACCUM_M = 2'd2,
    CMP_M   = 2'd3
  } xor_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  // Side-band flags carried with every result: neq, ovf, parity.
  localparam int unsigned RES_FLAG_W = 3;

endpackage

// File: rtl/xor_skid_buf.sv
// Two-entry valid/ready skid buffer. The head register drives the output
// directly; the skid register absorbs one extra beat while the consumer stalls.
module xor_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             head_vld_q, head_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    head_vld_d = head_vld_q;
    head_d     = head_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (!head_vld_q || out_ready_i) begin
      if (skid_vld_q) begin
        head_vld_d = 1'b1;
        head_d     = skid_q;
        skid_vld_d = in_valid_i;
        if (in_valid_i) skid_d = in_data_i;
      end else begin
        head_vld_d = in_valid_i;
        if (in_valid_i) head_d = in_data_i;
      end
    end else if (in_valid_i) begin
      // Head is stalled: the incoming beat parks in the skid slot.
      skid_vld_d = 1'b1;
      skid_d     = in_data_i;
    end
    ready_d = !(head_vld_d && skid_vld_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, because a cleared unit must present an all-zero result.
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      ready_q    <= 1'b0;
    end else if (!clr_n) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = head_vld_q;
  assign out_data_o  = head_q;

endmodule

// File: rtl/xor_stream_unit.sv
// Handshaked two-operand XOR unit with XOR/XNOR/ACCUM/CMP modes; results leave
// through a registered two-entry skid buffer.
module xor_stream_unit
  import xor_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                                 i__clk,
  input  logic                                 i__areset_n,
  input  logic                                 i__sreset_n,
  input  logic                                 i__valid,
  output logic                                 o__ready,
  input  logic [1:0]                           i__mode,
  input  logic                                 i__last,
  input  logic [DATA_WIDTH-1:0]                i__inA,
  input  logic [DATA_WIDTH-1:0]                i__inB,
  output logic                                 o__valid,
  input  logic                                 i__ready,
  output logic [DATA_WIDTH-1:0]                o__dout,
  output logic                                 o__parity,
  output logic                                 o__neq,
  output logic [$clog2(MAX_BURST+1)-1:0]       o__count,
  output logic                                 o__ovf
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned RES_W = DATA_WIDTH + CNT_W + RES_FLAG_W;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dout;
    logic [CNT_W-1:0]      count;
    logic                  neq;
    logic                  ovf;
    logic                  parity;
  } result_t;

  xor_mode_e             mode;
  burst_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ab;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  burst_full;
  logic                  accum_close;
  logic                  accum_beat;
  logic                  accept;
  logic                  push;
  result_t               res;
  result_t               out_res;

  assign mode        = xor_mode_e'(i__mode);
  assign accept      = i__valid && o__ready;
  assign ab          = i__inA ^ i__inB;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign burst_full  = (cnt_inc == CNT_W'(MAX_BURST));
  assign accum_close = i__last || burst_full;

  // Burst FSM: state register.
  always_ff @(posedge i__clk or negedge i__areset_n) begin
    if (!i__areset_n)      state_q <= IDLE;
    else if (!i__sreset_n) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  // Burst FSM: next state. A burst stays open until its emitting beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && mode == ACCUM_M && !accum_close) state_d = BURST;
      BURST: if (accept && accum_close)                     state_d = IDLE;
    endcase
  end

  // Burst FSM: output. Inside a burst the mode input is ignored.
  always_comb begin
    accum_beat = (state_q == BURST) || (mode == ACCUM_M);
  end

  always_comb begin
    res       = '0;
    res.count = CNT_W'(1);
    push      = accept;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (accum_beat) begin
      res.dout  = acc_q ^ ab;
      res.count = cnt_inc;
      res.ovf   = burst_full && !i__last;
      push      = accept && accum_close;
      if (accept) begin
        acc_d = accum_close ? '0 : (acc_q ^ ab);
        cnt_d = accum_close ? '0 : cnt_inc;
      end
    end else begin
      unique case (mode)
        XNOR_M:  res.dout = ~ab;
        CMP_M: begin
          res.dout = ab;
          res.neq  = |ab;
        end
        default: res.dout = ab;
      endcase
    end
    res.parity = ^res.dout;
  end

  always_ff @(posedge i__clk or negedge i__areset_n) begin
    if (!i__areset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (!i__sreset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  xor_skid_buf #(
    .WIDTH (RES_W)
  ) u_skid (
    .clk         (i__clk),
    .rst_n       (i__areset_n),
    .clr_n       (i__sreset_n),
    .in_valid_i  (push),
    .in_ready_o  (o__ready),
    .in_data_i   (res),
    .out_valid_o (o__valid),
    .out_ready_i (i__ready),
    .out_data_o  (out_res)
  );

  assign o__dout   = out_res.dout;
  assign o__count  = out_res.count;
  assign o__neq    = out_res.neq;
  assign o__ovf    = out_res.ovf;
  assign o__parity = out_res.parity;

endmodule

// File: tb/tb_xor_stream_unit.sv
// Self-checking bench for xor_stream_unit (MAX_BURST=4): directed scenarios plus
// random traffic, scored against a burst-list reference model.
module tb_xor_stream_unit;
  import xor_stream_pkg::*;

  localparam int DW   = 10;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);

  typedef struct packed {
    logic [DW-1:0] dout;
    logic [CW-1:0] count;
    logic          neq;
    logic          ovf;
    logic          parity;
  } res_t;

  logic          i__clk, i__areset_n, i__sreset_n;
  logic          i__valid, o__ready, i__last, o__valid, i__ready;
  logic [1:0]    i__mode;
  logic [DW-1:0] i__inA, i__inB, o__dout;
  logic          o__parity, o__neq, o__ovf;
  logic [CW-1:0] o__count;

  int     errors = 0;
  int     checks = 0;
  longint cycle  = 0;

  res_t          exp_q[$];
  res_t          got_q[$];
  logic [DW-1:0] burst_q[$];

  xor_stream_unit #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .i__clk(i__clk), .i__areset_n(i__areset_n), .i__sreset_n(i__sreset_n),
    .i__valid(i__valid), .o__ready(o__ready), .i__mode(i__mode), .i__last(i__last),
    .i__inA(i__inA), .i__inB(i__inB), .o__valid(o__valid), .i__ready(i__ready),
    .o__dout(o__dout), .o__parity(o__parity), .o__neq(o__neq),
    .o__count(o__count), .o__ovf(o__ovf)
  );

  initial i__clk = 1'b0;
  always #5 i__clk = ~i__clk;
  always @(posedge i__clk) cycle++;

  // Inputs change just after the rising edge, so at the falling edge the
  // handshake that the next rising edge will see is already settled.
  always @(negedge i__clk)
    if (i__areset_n && o__valid && i__ready)
      got_q.push_back(res_t'({o__dout, o__count, o__neq, o__ovf, o__parity}));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1);
  end

  function automatic res_t mk(input logic [DW-1:0] d, input int cnt, input logic neq, input logic ovf);
    mk = res_t'({d, CW'(cnt), neq, ovf, logic'($countones(d) % 2)});
  endfunction

  // Reference model: a burst is a list of A^B values folded when it closes.
  task automatic model_accept(input logic [1:0] m, input logic [DW-1:0] a, b, input logic l);
    logic [DW-1:0] fold;
    if (burst_q.size() == 0 && m != ACCUM_M) begin
      case (m)
        XOR_M:   exp_q.push_back(mk(a ^ b, 1, 1'b0, 1'b0));
        XNOR_M:  exp_q.push_back(mk(~(a ^ b), 1, 1'b0, 1'b0));
        default: exp_q.push_back(mk(a ^ b, 1, a != b, 1'b0));
      endcase
    end else begin
      burst_q.push_back(a ^ b);
      if (l || burst_q.size() == MAXB) begin
        fold = '0;
        foreach (burst_q[i]) fold = fold ^ burst_q[i];
        exp_q.push_back(mk(fold, burst_q.size(), 1'b0, !l));
        burst_q.delete();
      end
    end
  endtask

  task automatic send_beat(input logic [1:0] m, input logic [DW-1:0] a, b, input logic l);
    int waits = 0;
    i__valid = 1'b1; i__mode = m; i__inA = a; i__inB = b; i__last = l;
    @(negedge i__clk);
    while (!o__ready && waits < 200) begin
      waits++;
      @(negedge i__clk);
    end
    if (!o__ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: o__ready got 0 for %0d cycles, required 1", waits);
    end else begin
      model_accept(m, a, b, l);
    end
    @(posedge i__clk); #1;
    i__valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((got_q.size() < exp_q.size() || o__valid) && n < 300) begin
      @(posedge i__clk); #2;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s drain_timeout: got %0d results, required %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    i__areset_n = 1'b0; i__sreset_n = 1'b1; i__valid = 1'b0; i__ready = 1'b1;
    i__mode = 2'd0; i__last = 1'b0; i__inA = '0; i__inB = '0;
    repeat (3) @(posedge i__clk);
    @(negedge i__clk);
    checks++; if (o__valid  !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", o__valid); end
    checks++; if (o__dout   !== '0)   begin errors++; $display("FAIL reset_dout: got %h required 000", o__dout); end
    checks++; if (o__parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b required 0", o__parity); end
    checks++; if (o__neq    !== 1'b0) begin errors++; $display("FAIL reset_neq: got %b required 0", o__neq); end
    checks++; if (o__count  !== '0)   begin errors++; $display("FAIL reset_count: got %0d required 0", o__count); end
    checks++; if (o__ovf    !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", o__ovf); end
    i__areset_n = 1'b1;
    #1;
    checks++; if (o__ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b required 0", o__ready); end
    @(posedge i__clk); #1;
    checks++; if (o__ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b required 1", o__ready); end
  endtask

  task automatic test_xor();
    res_t g, e;
    send_beat(XOR_M, 10'h3FF, 10'h155, 1'b0);
    checks++; if (o__valid  !== 1'b1)   begin errors++; $display("FAIL xor_latency_valid: got %b required 1", o__valid); end
    checks++; if (o__dout   !== 10'h2AA) begin errors++; $display("FAIL xor_dout: got %h required 2aa", o__dout); end
    checks++; if (o__parity !== 1'b1)   begin errors++; $display("FAIL xor_parity: got %b required 1", o__parity); end
    checks++; if (o__count  !== CW'(1)) begin errors++; $display("FAIL xor_count: got %0d required 1", o__count); end
    checks++; if (o__neq    !== 1'b0)   begin errors++; $display("FAIL xor_neq: got %b required 0", o__neq); end
    wait_drain("xor");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL xor_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL xor_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_xnor_cmp();
    res_t g, e;
    send_beat(XNOR_M, 10'h0F0, 10'h0F0, 1'b0);
    checks++; if (o__dout   !== 10'h3FF) begin errors++; $display("FAIL xnor_dout: got %h required 3ff", o__dout); end
    checks++; if (o__parity !== 1'b0)    begin errors++; $display("FAIL xnor_parity: got %b required 0", o__parity); end
    send_beat(CMP_M, 10'h0F0, 10'h0F0, 1'b0);
    checks++; if (o__dout !== 10'h000) begin errors++; $display("FAIL cmp_eq_dout: got %h required 000", o__dout); end
    checks++; if (o__neq  !== 1'b0)    begin errors++; $display("FAIL cmp_eq_neq: got %b required 0", o__neq); end
    send_beat(CMP_M, 10'h155, 10'h0AA, 1'b0);
    checks++; if (o__neq  !== 1'b1)    begin errors++; $display("FAIL cmp_ne_neq: got %b required 1", o__neq); end
    wait_drain("xnor_cmp");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL xnor_cmp_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL xnor_cmp_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_accum();
    res_t g, e;
    send_beat(ACCUM_M, 10'h001, 10'h000, 1'b0);
    send_beat(XOR_M,   10'h002, 10'h000, 1'b0);
    send_beat(ACCUM_M, 10'h004, 10'h000, 1'b1);
    wait_drain("accum");
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL accum_nres: got %0d required 1", got_q.size());
    end else if (got_q[0].dout !== 10'h007 || got_q[0].count !== CW'(3) || got_q[0].ovf !== 1'b0) begin
      errors++; $display("FAIL accum_value: got dout=%h count=%0d ovf=%b required 007/3/0",
                         got_q[0].dout, got_q[0].count, got_q[0].ovf);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL accum_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    res_t g, e;
    for (int i = 1; i <= 5; i++) send_beat(ACCUM_M, DW'(i), 10'h000, 1'b0);
    send_beat(XOR_M, 10'h010, 10'h000, 1'b1);
    wait_drain("overflow");
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL ovf_nres: got %0d required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].dout !== 10'h004 || got_q[0].count !== CW'(4) || got_q[0].ovf !== 1'b1) begin
        errors++; $display("FAIL ovf_first: got dout=%h count=%0d ovf=%b required 004/4/1",
                           got_q[0].dout, got_q[0].count, got_q[0].ovf);
      end
      checks++;
      if (got_q[1].dout !== 10'h015 || got_q[1].count !== CW'(2) || got_q[1].ovf !== 1'b0) begin
        errors++; $display("FAIL ovf_second: got dout=%h count=%0d ovf=%b required 015/2/0",
                           got_q[1].dout, got_q[1].count, got_q[1].ovf);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ovf_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t   g, e;
    longint c0;
    i__ready = 1'b1;
    c0 = cycle;
    for (int i = 0; i < 6; i++) send_beat(XOR_M, DW'($urandom), DW'($urandom), 1'b0);
    checks++;
    if (cycle - c0 != 6) begin errors++; $display("FAIL b2b_throughput: got %0d cycles required 6", cycle - c0); end
    wait_drain("b2b");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    res_t          g, e;
    logic [DW-1:0] hold;
    i__ready = 1'b0;
    send_beat(XOR_M, DW'($urandom), DW'($urandom), 1'b0);
    send_beat(XOR_M, DW'($urandom), DW'($urandom), 1'b0);
    @(negedge i__clk);
    checks++; if (o__ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b required 0", o__ready); end
    checks++; if (o__valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", o__valid); end
    hold = o__dout;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(XOR_M, DW'($urandom), DW'($urandom), 1'b0);
      end
      begin
        repeat (4) begin
          @(negedge i__clk);
          checks++;
          if (o__dout !== hold || o__valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got valid=%b dout=%h required 1/%h", o__valid, o__dout, hold);
          end
        end
        @(posedge i__clk); #1;
        i__ready = 1'b1;
      end
    join
    wait_drain("backpressure");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bp_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sreset();
    res_t g, e;
    i__ready = 1'b1;
    send_beat(ACCUM_M, 10'h00C, 10'h000, 1'b0);
    i__sreset_n = 1'b0;
    i__valid = 1'b1; i__mode = ACCUM_M; i__inA = 10'h003; i__inB = 10'h000; i__last = 1'b1;
    @(posedge i__clk); #1;
    i__sreset_n = 1'b1; i__valid = 1'b0;
    burst_q.delete();
    checks++; if (o__ready !== 1'b0) begin errors++; $display("FAIL sreset_ready: got %b required 0", o__ready); end
    checks++; if (o__valid !== 1'b0) begin errors++; $display("FAIL sreset_valid: got %b required 0", o__valid); end
    send_beat(ACCUM_M, 10'h005, 10'h000, 1'b1);
    wait_drain("sreset");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sreset_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL sreset_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_areset_mid_burst();
    res_t g, e;
    i__ready = 1'b0;
    send_beat(XOR_M, 10'h2C3, 10'h001, 1'b0);
    send_beat(ACCUM_M, 10'h0AA, 10'h000, 1'b0);
    send_beat(ACCUM_M, 10'h0AA, 10'h000, 1'b0);
    #2;
    i__areset_n = 1'b0;
    #1;
    exp_q.delete(); burst_q.delete();
    checks++; if (o__valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b required 0", o__valid); end
    checks++; if (o__dout  !== '0)   begin errors++; $display("FAIL areset_dout: got %h required 000", o__dout); end
    checks++; if (o__count !== '0)   begin errors++; $display("FAIL areset_count: got %0d required 0", o__count); end
    checks++; if (o__ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b required 0", o__ready); end
    @(negedge i__clk);
    i__areset_n = 1'b1; i__ready = 1'b1;
    @(posedge i__clk); #1;
    send_beat(ACCUM_M, 10'h003, 10'h000, 1'b1);
    checks++;
    if (o__dout !== 10'h003 || o__count !== CW'(1)) begin
      errors++; $display("FAIL areset_new_burst: got dout=%h count=%0d required 003/1", o__dout, o__count);
    end
    wait_drain("areset");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL areset_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL areset_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    res_t g, e;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send_beat(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
        send_beat(ACCUM_M, 10'h000, 10'h000, 1'b1);
      end
      begin
        repeat (100) begin
          @(posedge i__clk); #1;
          i__ready = ($urandom_range(0, 3) != 0);
        end
        i__ready = 1'b1;
      end
    join
    wait_drain("random");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_nres: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rand_result: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_xor();
    test_xnor_cmp();
    test_accum();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_sreset();
    test_areset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
